// File: rtl/conv1_buf.sv
// conv1_buf: 3x3 sliding-window generator over a raster stream of 1-bit pixels.
// Two line buffers hold the previous rows; the window register doubles as the output.
module conv1_buf #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_in,
    input  logic pixel_in,
    output logic pixel_0,
    output logic pixel_1,
    output logic pixel_2,
    output logic pixel_3,
    output logic pixel_4,
    output logic pixel_5,
    output logic pixel_6,
    output logic pixel_7,
    output logic pixel_8,
    output logic valid_out_buf,
    output logic img_done
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [IMG_WIDTH-1:0] lb1;
    logic [IMG_WIDTH-1:0] lb2;
    logic [2:0]           w_top;
    logic [2:0]           w_mid;
    logic [2:0]           w_bot;

    logic col_last;
    logic row_last;
    logic win_ok;
    logic up1;
    logic up2;

    assign col_last = (col == CW'(IMG_WIDTH - 1));
    assign row_last = (row == RW'(IMG_HEIGHT - 1));
    assign win_ok   = (row >= RW'(2)) && (col >= CW'(2));
    assign up1      = lb1[col];
    assign up2      = lb2[col];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Same-column shift: row r-1 moves to r-2 as row r lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb1 <= '0;
            lb2 <= '0;
        end else if (valid_in) begin
            lb1[col] <= pixel_in;
            lb2[col] <= up1;
        end
    end

    // Bit 2 is column c-2, bit 0 is the newest column c.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_top <= '0;
            w_mid <= '0;
            w_bot <= '0;
        end else if (valid_in) begin
            w_top <= {w_top[1:0], up2};
            w_mid <= {w_mid[1:0], up1};
            w_bot <= {w_bot[1:0], pixel_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out_buf <= 1'b0;
            img_done      <= 1'b0;
        end else begin
            valid_out_buf <= valid_in && win_ok;
            img_done      <= valid_in && col_last && row_last;
        end
    end

    assign pixel_0 = w_top[2];
    assign pixel_1 = w_top[1];
    assign pixel_2 = w_top[0];
    assign pixel_3 = w_mid[2];
    assign pixel_4 = w_mid[1];
    assign pixel_5 = w_mid[0];
    assign pixel_6 = w_bot[2];
    assign pixel_7 = w_bot[1];
    assign pixel_8 = w_bot[0];

endmodule

// File: tb/tb_conv1_buf.sv
// Bench for conv1_buf: raster-array reference model, per-cycle compare,
// plus a small 5x4 geometry instance checked against literal windows.
module tb_conv1_buf;

    localparam int W = 28;
    localparam int H = 28;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_in = 1'b0;
    logic pixel_in = 1'b0;
    logic p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic vout, done;

    logic s_valid = 1'b0;
    logic s_pixel = 1'b0;
    logic q0, q1, q2, q3, q4, q5, q6, q7, q8;
    logic s_vout, s_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv1_buf #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .pixel_in(pixel_in),
        .pixel_0(p0), .pixel_1(p1), .pixel_2(p2), .pixel_3(p3), .pixel_4(p4),
        .pixel_5(p5), .pixel_6(p6), .pixel_7(p7), .pixel_8(p8),
        .valid_out_buf(vout), .img_done(done)
    );

    conv1_buf #(.IMG_WIDTH(5), .IMG_HEIGHT(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .valid_in(s_valid), .pixel_in(s_pixel),
        .pixel_0(q0), .pixel_1(q1), .pixel_2(q2), .pixel_3(q3), .pixel_4(q4),
        .pixel_5(q5), .pixel_6(q6), .pixel_7(q7), .pixel_8(q8),
        .valid_out_buf(s_vout), .img_done(s_done)
    );

    wire [8:0] win   = {p0, p1, p2, p3, p4, p5, p6, p7, p8};
    wire [8:0] s_win = {q0, q1, q2, q3, q4, q5, q6, q7, q8};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: store the current image by raster index, cut windows from it.
    bit       img[N];
    int       m_idx;
    bit       exp_valid;
    bit       exp_done;
    bit [8:0] exp_win;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idx     = 0;
            exp_valid = 1'b0;
            exp_done  = 1'b0;
        end else begin
            exp_valid = 1'b0;
            exp_done  = 1'b0;
            if (valid_in) begin
                int r;
                int c;
                r = m_idx / W;
                c = m_idx % W;
                img[m_idx] = pixel_in;
                if (r >= 2 && c >= 2) begin
                    exp_valid = 1'b1;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            exp_win[8 - (i * 3 + j)] = img[(r - 2 + i) * W + c - 2 + j];
                    exp_done = (m_idx == N - 1);
                end
                m_idx = (m_idx + 1) % N;
            end
        end
    end

    int       win_cnt = 0;
    int       done_cnt = 0;
    int       zero_wins = 0;
    int       one_wins = 0;
    bit [8:0] first_win = '0;

    always @(negedge clk) begin
        chk("valid_out_buf", int'(vout), int'(exp_valid));
        chk("img_done", int'(done), int'(exp_done));
        if (exp_valid)
            chk("window", int'(win), int'(exp_win));
        if (vout) begin
            if (win_cnt == 0) first_win = win;
            win_cnt++;
            if (win == 9'h000) zero_wins++;
            if (win == 9'h1ff) one_wins++;
        end
        if (done) done_cnt++;
    end

    function automatic bit px(input int kind, input int k);
        case (kind)
            0: return bit'(((k / W) + (k % W)) & 1);
            1: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic send_px(input int kind, input int gap, input int from, input int to);
        for (int k = from; k < to; k++) begin
            while (gap > 0 && $urandom_range(99) < gap) begin
                valid_in = 1'b0;
                pixel_in = 1'($urandom);
                @(negedge clk);
            end
            valid_in = 1'b1;
            pixel_in = px(kind, k % N);
            @(negedge clk);
        end
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        win_cnt   = 0;
        done_cnt  = 0;
        zero_wins = 0;
        one_wins  = 0;
        first_win = '0;
    endtask

    task automatic small_test();
        int nw;
        nw = 0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 20; k++) begin
            int r;
            int c;
            bit [8:0] e;
            r = k / 5;
            c = k % 5;
            s_valid = 1'b1;
            s_pixel = bit'(k & 1);
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            if (r >= 2 && c >= 2) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e[8 - (i * 3 + j)] = bit'(((r - 2 + i) * 5 + c - 2 + j) & 1);
                chk("small_valid", int'(s_vout), 1);
                chk("small_window", int'(s_win), int'(e));
                if (nw == 0)
                    chk("small_first_window", int'(s_win), 9'b010101010);
                nw++;
                chk("small_done", int'(s_done), (nw == 6) ? 1 : 0);
            end else begin
                chk("small_valid", int'(s_vout), 0);
                chk("small_done", int'(s_done), 0);
            end
        end
        @(posedge clk);
        #1;
        chk("small_idle_valid", int'(s_vout), 0);
        chk("small_windows", nw, 6);
    endtask

    initial begin
        @(negedge clk);
        // Reset with random input activity: outputs must stay zero.
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'($urandom);
            pixel_in = 1'($urandom);
            @(negedge clk);
            chk("reset_outputs", int'({win, vout, done}), 0);
        end
        valid_in = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        clear_counts();

        send_px(0, 0, 0, 58);
        idle(2);
        chk("no_window_after_58", win_cnt, 0);
        send_px(0, 0, 58, N);
        idle(2);
        chk("checker_windows", win_cnt, 676);
        chk("checker_done", done_cnt, 1);
        chk("checker_first_window", int'(first_win), 9'b010101010);

        clear_counts();
        send_px(0, 40, 0, N);
        idle(2);
        chk("gap_windows", win_cnt, 676);
        chk("gap_done", done_cnt, 1);
        chk("gap_first_window", int'(first_win), 9'b010101010);

        clear_counts();
        send_px(1, 0, 0, N);
        send_px(2, 0, 0, N);
        idle(2);
        chk("b2b_windows", win_cnt, 1352);
        chk("b2b_zero_windows", zero_wins, 676);
        chk("b2b_one_windows", one_wins, 676);
        chk("b2b_done", done_cnt, 2);

        send_px(0, 0, 0, 100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({win, vout, done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_counts();
        send_px(0, 0, 0, N);
        idle(2);
        chk("midreset_windows", win_cnt, 676);
        chk("midreset_done", done_cnt, 1);
        chk("midreset_first_window", int'(first_win), 9'b010101010);

        small_test();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
